// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller: FSM states,
// func3 access-size codes and the registered request bundle.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

  // Undefined func3 codes fall through to a full-word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      FUNC3_B, FUNC3_BU: f3_size = SZ_B;
      FUNC3_H, FUNC3_HU: f3_size = SZ_H;
      default:           f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational load/store lane formatting: store byte enables and replicated
// write data, alignment check, and sign/zero-extended load extraction.
module lsu_fmt
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] b_shift;
  logic [31:0] h_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  always_comb begin
    be         = 4'b1111;
    wdata      = st_data;
    misaligned = 1'b0;
    case (f3_size(st_func3))
      SZ_B: begin
        be    = 4'b0001 << st_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be         = st_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
        misaligned = st_lo[0];
      end
      default: misaligned = |st_lo;
    endcase
  end

  assign b_shift = rdata >> {ld_lo, 3'b000};
  assign h_shift = rdata >> {ld_lo[1], 4'b0000};
  assign ld_byte = b_shift[7:0];
  assign ld_half = h_shift[15:0];
  // func3[2] set selects the unsigned variants
  assign sext    = ~ld_func3[2];

  always_comb begin
    ld_data = rdata;
    case (f3_size(ld_func3))
      SZ_B:    ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{sext & ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: one valid/ready request, one response, then a
// single DONE bubble. Stalls the front of the pipeline while busy.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  input  logic [2:0]  me_func3_code,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        mem_stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state, state_nxt;
  dmem_req_t   req_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [7:0]  cnt;
  logic        access, start, mis_hit, rsp_hit, tmo;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_ld;
  logic        fmt_mis;

  assign access = me_mem_read | me_mem_write;

  // Load side uses the func3/offset captured at issue, not the live EX/MEM copy.
  lsu_fmt u_fmt (
    .st_func3   (me_func3_code),
    .st_lo      (me_alu_o[1:0]),
    .st_data    (me_regs_data2),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .misaligned (fmt_mis),
    .ld_func3   (f3_q),
    .ld_lo      (lo_q),
    .rdata      (dmem_rsp_rdata),
    .ld_data    (fmt_ld)
  );

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    start     = 1'b0;
    mis_hit   = 1'b0;
    rsp_hit   = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          if (fmt_mis) begin
            mis_hit = 1'b1;
          end else begin
            start     = 1'b1;
            mem_stall = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (dmem_req_ready) state_nxt = S_RSP;
      end
      S_RSP: begin
        mem_stall = 1'b1;
        if (dmem_rsp_valid) begin
          rsp_hit   = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_q        <= '0;
      f3_q         <= '0;
      lo_q         <= '0;
      cnt          <= '0;
      ld_data      <= '0;
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      ld_valid     <= rsp_hit & ~req_q.we;
      misalign_err <= mis_hit;
      bus_err      <= tmo;
      if (start) begin
        // Write wins when read and write are both flagged.
        req_q <= '{we:    me_mem_write,
                   addr:  {me_alu_o[31:2], 2'b00},
                   be:    fmt_be,
                   wdata: fmt_wdata};
        f3_q  <= me_func3_code;
        lo_q  <= me_alu_o[1:0];
      end
      if (state == S_REQ)      cnt <= '0;
      else if (state == S_RSP) cnt <= cnt + 8'd1;
      if (rsp_hit && !req_q.we) ld_data <= fmt_ld;
      else if (tmo)             ld_data <= '0;
    end
  end

  assign dmem_req_valid = (state == S_REQ);
  assign dmem_we        = req_q.we;
  assign dmem_addr      = req_q.addr;
  assign dmem_be        = req_q.be;
  assign dmem_wdata     = req_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a bench-side memory answers requests
// with programmable ready/response delays; each scenario checks its own results.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_mem_read, me_mem_write;
  logic [31:0] me_alu_o, me_regs_data2;
  logic [2:0]  me_func3_code;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        mem_stall, ld_valid, misalign_err, bus_err;
  logic [31:0] ld_data;

  int checks = 0;
  int failures = 0;

  // results of the last do_access
  int          r_stall, r_reqv;
  bit          r_stable, r_ldv, r_bus, r_done;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_ldd;
  logic [3:0]  r_be;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_func3_code(me_func3_code),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .mem_stall(mem_stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    me_mem_read    = 1'b0;
    me_mem_write   = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h0;
  endtask

  // Presents one instruction in EX/MEM and plays the memory until the DONE bubble.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3,
                           input int rdy_wait, input int rsp_wait,
                           input logic [31:0] rdata, input bit respond);
    bit in_rsp = 0;
    bit seen_stall = 0;
    int rsp_idx = 0;
    r_stall = 0; r_reqv = 0; r_stable = 1; r_ldv = 0; r_bus = 0; r_done = 0;
    r_we = 0; r_addr = 0; r_wdata = 0; r_be = 0; r_ldd = 0;
    me_mem_read = rd; me_mem_write = wr; me_alu_o = a; me_regs_data2 = d; me_func3_code = f3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      dmem_req_ready = dmem_req_valid && (r_reqv >= rdy_wait);
      dmem_rsp_valid = respond && in_rsp && (rsp_idx == rsp_wait);
      dmem_rsp_rdata = dmem_rsp_valid ? rdata : 32'hDEAD_BEEF;
      #1;
      if (dmem_req_valid) begin
        if (r_reqv == 0) begin
          r_we = dmem_we; r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata;
        end else if (dmem_we !== r_we || dmem_addr !== r_addr || dmem_be !== r_be ||
                     dmem_wdata !== r_wdata) begin
          r_stable = 0;
        end
        r_reqv++;
      end
      if (ld_valid) r_ldv = 1;
      if (bus_err)  r_bus = 1;
      if (mem_stall) begin
        r_stall++;
        seen_stall = 1;
      end else if (seen_stall) begin
        r_done = 1;
        r_ldd  = ld_data;
        break;
      end
      if (in_rsp) rsp_idx++;
      if (dmem_req_valid && dmem_req_ready) in_rsp = 1;
      tick();
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    me_alu_o = 0; me_regs_data2 = 0; me_func3_code = 0;
    repeat (3) tick();
    #1;
    checks++; if (dmem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", dmem_req_valid); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL reset_ld_data got=%h exp=0", ld_data); end
    checks++; if ({ld_valid, misalign_err, bus_err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {ld_valid, misalign_err, bus_err}); end
    checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin failures++; $display("FAIL reset_req_fields got=%h exp=0", {dmem_we, dmem_be, dmem_addr, dmem_wdata}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    do_access(0, 1, 32'h100, 32'h1234_5678, 3'b010, 0, 0, 32'h0, 1);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL sw_done got=%0d exp=1", r_done); end
    checks++; if (r_stall !== 3) begin failures++; $display("FAIL sw_stall_cycles got=%0d exp=3", r_stall); end
    checks++; if (r_reqv !== 1) begin failures++; $display("FAIL sw_req_cycles got=%0d exp=1", r_reqv); end
    checks++; if ({r_we, r_be} !== 5'b1_1111) begin failures++; $display("FAIL sw_we_be got=%b exp=11111", {r_we, r_be}); end
    checks++; if (r_addr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", r_addr); end
    checks++; if (r_wdata !== 32'h1234_5678) begin failures++; $display("FAIL sw_wdata got=%h exp=12345678", r_wdata); end
    checks++; if (r_ldv !== 0) begin failures++; $display("FAIL sw_ld_valid got=%0d exp=0", r_ldv); end
  endtask

  task automatic test_store_sub();
    do_access(0, 1, 32'h103, 32'h1234_56AB, 3'b000, 0, 0, 32'h0, 1);
    checks++; if (r_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", r_be); end
    checks++; if (r_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", r_wdata); end
    checks++; if (r_addr !== 32'h100) begin failures++; $display("FAIL sb_addr got=%h exp=00000100", r_addr); end
    do_access(0, 1, 32'h102, 32'hDEAD_BEEF, 3'b001, 0, 0, 32'h0, 1);
    checks++; if ({r_be, r_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin failures++; $display("FAIL sh_be_wdata got=%b/%h exp=1100/beefbeef", r_be, r_wdata); end
  endtask

  task automatic test_load_byte();
    do_access(1, 0, 32'h101, 32'h0, 3'b000, 0, 0, 32'h0000_8000, 1);
    checks++; if (r_ldv !== 1) begin failures++; $display("FAIL lb_ld_valid got=%0d exp=1", r_ldv); end
    checks++; if (r_ldd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", r_ldd); end
    checks++; if ({r_we, r_addr} !== {1'b0, 32'h100}) begin failures++; $display("FAIL lb_we_addr got=%b/%h exp=0/00000100", r_we, r_addr); end
    checks++; if (r_stall !== 3) begin failures++; $display("FAIL lb_stall_cycles got=%0d exp=3", r_stall); end
    do_access(1, 0, 32'h101, 32'h0, 3'b100, 0, 0, 32'h0000_8000, 1);
    checks++; if (r_ldd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", r_ldd); end
    // ld_valid must be a single-cycle pulse
    #1;
    checks++; if (ld_valid !== 1'b0) begin failures++; $display("FAIL lbu_pulse_width got=%b exp=0", ld_valid); end
  endtask

  task automatic test_wait_states();
    do_access(1, 0, 32'h2, 32'h0, 3'b001, 5, 3, 32'h8001_1234, 1);
    checks++; if (r_reqv !== 6) begin failures++; $display("FAIL lh_req_cycles got=%0d exp=6", r_reqv); end
    checks++; if (r_stable !== 1) begin failures++; $display("FAIL lh_req_stable got=%0d exp=1", r_stable); end
    checks++; if (r_stall !== 11) begin failures++; $display("FAIL lh_stall_cycles got=%0d exp=11", r_stall); end
    checks++; if (r_ldd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", r_ldd); end
    checks++; if (r_addr !== 32'h0) begin failures++; $display("FAIL lh_addr got=%h exp=00000000", r_addr); end
    do_access(1, 0, 32'h106, 32'h0, 3'b101, 0, 1, 32'h8001_1234, 1);
    checks++; if (r_ldd !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", r_ldd); end
    do_access(1, 0, 32'h104, 32'h0, 3'b010, 2, 0, 32'hCAFE_F00D, 1);
    checks++; if (r_ldd !== 32'hCAFE_F00D) begin failures++; $display("FAIL lw_data got=%h exp=cafef00d", r_ldd); end
  endtask

  task automatic test_read_write_both();
    do_access(1, 1, 32'h108, 32'h0BAD_CAFE, 3'b010, 0, 0, 32'h1111_1111, 1);
    checks++; if (r_we !== 1'b1) begin failures++; $display("FAIL rw_we got=%b exp=1", r_we); end
    checks++; if (r_ldv !== 0) begin failures++; $display("FAIL rw_ld_valid got=%0d exp=0", r_ldv); end
    checks++; if (r_ldd !== 32'hCAFE_F00D) begin failures++; $display("FAIL rw_ld_held got=%h exp=cafef00d", r_ldd); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3];
    logic [2:0]  f3s [3];
    addrs[0] = 32'h102; f3s[0] = 3'b010;
    addrs[1] = 32'h101; f3s[1] = 3'b001;
    addrs[2] = 32'h101; f3s[2] = 3'b011;
    for (int i = 0; i < 3; i++) begin
      me_mem_read = 1'b1; me_alu_o = addrs[i]; me_func3_code = f3s[i];
      #1;
      checks++; if ({mem_stall, dmem_req_valid} !== 2'b00) begin failures++; $display("FAIL mis%0d_stall_req got=%b exp=00", i, {mem_stall, dmem_req_valid}); end
      tick();
      me_mem_read = 1'b0;
      #1;
      checks++; if ({misalign_err, dmem_req_valid} !== 2'b10) begin failures++; $display("FAIL mis%0d_pulse got=%b exp=10", i, {misalign_err, dmem_req_valid}); end
      tick();
      #1;
      checks++; if ({misalign_err, dmem_req_valid} !== 2'b00) begin failures++; $display("FAIL mis%0d_after got=%b exp=00", i, {misalign_err, dmem_req_valid}); end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_access(1, 0, 32'h200, 32'h0, 3'b010, 0, 0, 32'h0, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL tmo_done got=%0d exp=1", r_done); end
    checks++; if (r_bus !== 1) begin failures++; $display("FAIL tmo_bus_err got=%0d exp=1", r_bus); end
    checks++; if (r_stall !== 257) begin failures++; $display("FAIL tmo_stall_cycles got=%0d exp=257", r_stall); end
    checks++; if ({r_ldv, r_ldd} !== 33'h0) begin failures++; $display("FAIL tmo_ld got=%b/%h exp=0/00000000", r_ldv, r_ldd); end
  endtask

  task automatic test_reset_mid_access();
    do_access(1, 0, 32'h10, 32'h0, 3'b010, 0, 0, 32'h5555_AAAA, 1);
    checks++; if (r_ldd !== 32'h5555_AAAA) begin failures++; $display("FAIL pre_rst_data got=%h exp=5555aaaa", r_ldd); end
    me_mem_read = 1'b1; me_alu_o = 32'h14; me_func3_code = 3'b010;
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    tick();
    #1;
    checks++; if ({mem_stall, dmem_req_valid} !== 2'b10) begin failures++; $display("FAIL mid_rsp_state got=%b exp=10", {mem_stall, dmem_req_valid}); end
    rst = 1'b1;
    clear_inputs();
    tick();
    #1;
    checks++; if ({dmem_req_valid, mem_stall, ld_valid, misalign_err, bus_err} !== 5'b0) begin failures++; $display("FAIL mid_rst_ctrl got=%b exp=00000", {dmem_req_valid, mem_stall, ld_valid, misalign_err, bus_err}); end
    checks++; if ({ld_data, dmem_addr, dmem_be, dmem_we} !== '0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", ld_data, dmem_addr); end
    rst = 1'b0;
    tick();
    // a fresh access after reset must still complete normally
    do_access(0, 1, 32'h20, 32'h0000_00C3, 3'b000, 0, 0, 32'h0, 1);
    checks++; if ({r_done, r_be, r_wdata} !== {1'b1, 4'b0001, 32'hC3C3_C3C3}) begin failures++; $display("FAIL post_rst_sb got=%b/%b/%h exp=1/0001/c3c3c3c3", r_done, r_be, r_wdata); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_sub();
    test_load_byte();
    test_wait_states();
    test_read_write_both();
    test_misalign();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
